stack_queue: RTL
================

// Module: stack_queue
// PURPOSE
//   Parametrised dual-mode storage buffer: stack (LIFO) or queue (FIFO), selected at run time.
//   Single-cycle push/pop ops with a registered pop output.
//   Occupancy, almost-full and sticky overflow/underflow error flags.
//   Next-generation replacement for the fixed-mode stack in data-buffering paths.
// PARAMETERS
//   DEPTH      6    number of entries (any value >= 2, not restricted to powers of 2)
//   DATA_W     10   data word width in bits
//   AFULL_TH   4    almost_full asserts when count >= AFULL_TH (1..DEPTH)
//   CNT_W      $clog2(DEPTH+1)  count width (derived, do not override)
// PORTS
//   clock       in   1       rising-edge clock
//   reset       in   1       synchronous, active-low reset
//   mode        in   1       0 = LIFO, 1 = FIFO; sampled only while empty
//   push        in   1       write datain this cycle (level; one op per asserted cycle)
//   pop         in   1       read one entry this cycle (level; one op per asserted cycle)
//   datain      in   DATA_W  write data
//   clr_err     in   1       clears overflow/underflow
//   dataout     out  DATA_W  popped word, registered
//   val         out  1       dataout valid; one-cycle pulse per successful pop
//   full        out  1       count == DEPTH
//   empty       out  1       count == 0
//   almost_full out  1       count >= AFULL_TH
//   count       out  CNT_W   current occupancy
//   overflow    out  1       sticky: push rejected while full
//   underflow   out  1       sticky: pop rejected while empty
//   cur_mode    out  1       mode currently in effect
// BEHAVIOUR
//   Reset (reset==0 at a clock edge):
//     dataout=0, val=0, count=0, empty=1, full=0, almost_full=0.
//     overflow=0, underflow=0, cur_mode=0; pointers=0. Memory contents are not cleared.
//   Mode: cur_mode <= mode on any edge where empty==1 and no push occurs.
//     Otherwise cur_mode holds; changing mode while non-empty has no effect.
//   Storage: circular array with wr_ptr and rd_ptr.
//     Pointer increment wraps DEPTH-1 -> 0 and decrement wraps 0 -> DEPTH-1 (explicit compare, no mod-2^n).
//     FIFO: push writes at wr_ptr, wr_ptr++; pop reads rd_ptr, rd_ptr++.
//     LIFO: top = wr_ptr-1; push writes wr_ptr, wr_ptr++; pop reads top, wr_ptr--.
//   Pop latency: 1 cycle. dataout/val update at the edge ending the pop cycle.
//     val=0 on every cycle without a successful pop; dataout holds its last value.
//   Status (full/empty/almost_full/count) is combinational from count.
//     It reflects the state after the previous edge.
//   Push only: if !full, store and count++. If full, drop data, set overflow, no state change.
//   Pop only: if !empty, output and count--. If empty, set underflow, val stays 0.
//   push & pop same cycle:
//     empty: the push executes (count 0->1); the pop is rejected, underflow set, val=0.
//     non-empty (including full): both execute; count unchanged; no overflow.
//       LIFO: dataout = old top; datain overwrites that slot; wr_ptr unchanged.
//       FIFO: dataout = head; datain written at tail; both pointers advance.
//   Errors: overflow/underflow stay set until clr_err==1 at an edge.
//     If clr_err and a new error occur in the same cycle, the error wins (flag stays 1).
//   Reset mid-operation: a push or pop in the reset cycle is discarded.
//     All outputs return to their reset values at that edge.
// TESTING
//   1. LIFO, DEPTH=6: push 1..6 -> full=1, almost_full=1 from count 4.
//      Pop x6 -> dataout 6,5,4,3,2,1, each with val=1; then empty=1.
//   2. FIFO: push 1..6, pop x6 -> 1..6 in order.
//      Push 7,8 and pop x2 -> 7,8; this exercises wrap of both pointers at DEPTH=6.
//   3. Full + push 9 -> overflow=1, count stays 6, contents unchanged.
//      Empty + pop -> underflow=1, val=0. clr_err -> both flags 0 next cycle.
//   4. LIFO holding 1,2,3; push 9 & pop together -> dataout=3, count=3.
//      Next pop -> 9. FIFO holding 1,2,3, same stimulus -> dataout=1; later pops give 2,3,9.
//   5. Hold mode=1 while LIFO is non-empty -> cur_mode stays 0.
//      After the buffer drains, cur_mode=1 on the next idle edge.
//   6. Assert reset=0 mid-burst with push=1 -> count=0, empty=1, val=0, flags=0, cur_mode=0.
//      The pushed word is not stored.

Source files
------------

// File: rtl/stack_queue.sv
// stack_queue: dual-mode (LIFO / FIFO) storage buffer over a circular array.
// One push and/or one pop per cycle, registered pop data with a valid pulse,
// occupancy status, and sticky overflow/underflow flags.
module stack_queue #(
   parameter  int DEPTH    = 6,
   parameter  int DATA_W   = 10,
   parameter  int AFULL_TH = 4,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mode,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] datain,
   input  logic              clr_err,
   output logic [DATA_W-1:0] dataout,
   output logic              val,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow,
   output logic              cur_mode
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_AF  = CNT_W'(AFULL_TH);

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dataout_q, dataout_d;
   logic              val_q, val_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              mode_q, mode_d;

   logic              wr_en;
   logic [PTR_W-1:0]  wr_addr;
   logic [PTR_W-1:0]  rd_addr;
   logic [PTR_W-1:0]  top;
   logic              is_empty, is_full;

   // Wrap by explicit compare so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_MAX : p - PTR_W'(1);
   endfunction

   assign is_empty    = (count_q == '0);
   assign is_full     = (count_q == CNT_MAX);
   assign top         = ptr_dec(wr_ptr_q);

   assign empty       = is_empty;
   assign full        = is_full;
   assign almost_full = (count_q >= CNT_AF);
   assign count       = count_q;
   assign dataout     = dataout_q;
   assign val         = val_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign cur_mode    = mode_q;

   // Next-state: decode the push/pop combination against current occupancy and mode.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      dataout_d = dataout_q;
      val_d     = 1'b0;
      ovf_d     = ovf_q & ~clr_err;
      unf_d     = unf_q & ~clr_err;
      mode_d    = mode_q;
      wr_en     = 1'b0;
      wr_addr   = wr_ptr_q;
      rd_addr   = mode_q ? rd_ptr_q : top;

      if (push && pop) begin
         if (is_empty) begin
            // Nothing to pop yet: the write goes through, the read is an error.
            wr_en    = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + CNT_W'(1);
            unf_d    = 1'b1;
         end else begin
            dataout_d = mem_q[rd_addr];
            val_d     = 1'b1;
            wr_en     = 1'b1;
            if (mode_q) begin
               wr_ptr_d = ptr_inc(wr_ptr_q);
               rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
               // Replace the top in place; the old top is read before the write lands.
               wr_addr = top;
            end
         end
      end else if (push) begin
         if (is_full) begin
            ovf_d = 1'b1;
         end else begin
            wr_en    = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d  = count_q + CNT_W'(1);
         end
      end else if (pop) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else begin
            dataout_d = mem_q[rd_addr];
            val_d     = 1'b1;
            count_d   = count_q - CNT_W'(1);
            if (mode_q) rd_ptr_d = ptr_inc(rd_ptr_q);
            else        wr_ptr_d = top;
         end
      end

      if (is_empty && !push) mode_d = mode;

      // A push coincident with reset must not reach the array.
      if (!reset) wr_en = 1'b0;
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         dataout_q <= '0;
         val_q     <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         dataout_q <= dataout_d;
         val_q     <= val_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         mode_q    <= mode_d;
      end
   end

   // Storage array write port; contents are never cleared.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_addr] <= datain;
   end

endmodule
